// File: rtl/dcache_direct_mapped_if.sv
// CPU load/store and main-memory line bus of the MEM-stage data cache.
// The master side is the core/memory environment, the slave side the cache.
interface dcache_direct_mapped_if #(
  parameter int LINE_WORDS_LOG = 3
);
  localparam int LINE_W = 32 << LINE_WORDS_LOG;

  logic              rd_req;
  logic              wr_req;
  logic [31:0]       addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic [31:0]       rd_data;
  logic              miss;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wr_line;
  logic [LINE_W-1:0] mem_rd_line;
  logic              mem_gnt;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport master (
    output rd_req, wr_req, addr, wr_data, wr_be,
    output mem_rd_line, mem_gnt,
    input  rd_data, miss, mem_rd_req, mem_wr_req,
    input  mem_addr, mem_wr_line, hit_count, miss_count
  );

  modport slave (
    input  rd_req, wr_req, addr, wr_data, wr_be,
    input  mem_rd_line, mem_gnt,
    output rd_data, miss, mem_rd_req, mem_wr_req,
    output mem_addr, mem_wr_line, hit_count, miss_count
  );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Misses stall the core while the victim is written back and the line refilled.
module dcache_direct_mapped #(
  parameter int LINE_WORDS_LOG = 3,
  parameter int SET_LOG        = 3
) (
  input logic                 clk,
  input logic                 rst,
  dcache_direct_mapped_if.slave bus
);
  localparam int TAG_W  = 30 - LINE_WORDS_LOG - SET_LOG;
  localparam int WORDS  = 1 << LINE_WORDS_LOG;
  localparam int SETS   = 1 << SET_LOG;
  localparam int LINE_W = 32 * WORDS;
  localparam int OFF_W  = LINE_WORDS_LOG + 2;

  typedef enum logic [1:0] {
    IDLE,
    SWAP_OUT,
    SWAP_IN,
    SWAP_IN_OK
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       data_q [SETS][WORDS];
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [LINE_W-1:0] fill_q;
  logic              rd_q;
  logic              wr_q;
  logic              retry_q;
  logic [31:0]       hits_q;
  logic [31:0]       misses_q;

  logic [LINE_WORDS_LOG-1:0] word_no;
  logic [SET_LOG-1:0]        set_no;
  logic [TAG_W-1:0]          tag;
  logic                      req;
  logic                      hit;
  logic                      hit_idle;
  logic                      store_hit;
  logic [31:0]               maddr;
  logic [LINE_W-1:0]         victim;
  logic                      unused_lsb;

  assign word_no    = bus.addr[OFF_W-1:2];
  assign set_no     = bus.addr[OFF_W+SET_LOG-1:OFF_W];
  assign tag        = bus.addr[31:OFF_W+SET_LOG];
  assign unused_lsb = ^bus.addr[1:0];

  assign req       = bus.rd_req | bus.wr_req;
  assign hit       = valid_q[set_no] && (tag_q[set_no] == tag);
  assign hit_idle  = (state_q == IDLE) && hit;
  assign store_hit = bus.wr_req && hit_idle;

  assign bus.miss        = req && !hit_idle;
  assign bus.rd_data     = data_q[set_no][word_no];
  assign bus.mem_rd_req  = rd_q;
  assign bus.mem_wr_req  = wr_q;
  assign bus.mem_addr    = maddr;
  assign bus.mem_wr_line = victim;
  assign bus.hit_count   = hits_q;
  assign bus.miss_count  = misses_q;

  // Write-back targets the resident line, refill the requested one.
  always_comb begin
    maddr = {tag, set_no, {OFF_W{1'b0}}};
    if (state_q == SWAP_OUT) begin
      maddr = {tag_q[set_no], set_no, {OFF_W{1'b0}}};
    end
  end

  always_comb begin
    victim = '0;
    for (int w = 0; w < WORDS; w++) begin
      victim[w*32 +: 32] = data_q[set_no][w];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = (valid_q[set_no] && dirty_q[set_no]) ? SWAP_OUT : SWAP_IN;
        end
      end
      SWAP_OUT: if (bus.mem_gnt) state_d = SWAP_IN;
      SWAP_IN:  if (bus.mem_gnt) state_d = SWAP_IN_OK;
      SWAP_IN_OK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      retry_q  <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= state_d == SWAP_IN;
      wr_q    <= state_d == SWAP_OUT;
      retry_q <= state_q == SWAP_IN_OK;
      // The retry straight after a refill is not a real hit.
      if (req && hit_idle && !retry_q) hits_q <= hits_q + 32'd1;
      if (req && state_q == IDLE && !hit) misses_q <= misses_q + 32'd1;
      if (state_q == SWAP_IN_OK) begin
        valid_q[set_no] <= 1'b1;
        dirty_q[set_no] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[set_no] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == SWAP_IN && bus.mem_gnt) fill_q <= bus.mem_rd_line;
      if (state_q == SWAP_IN_OK) begin
        tag_q[set_no] <= tag;
        for (int w = 0; w < WORDS; w++) begin
          data_q[set_no][w] <= fill_q[w*32 +: 32];
        end
      end else if (store_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.wr_be[b]) begin
            data_q[set_no][word_no][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
          end
        end
      end
    end
  end
endmodule
